wb_mult8_slave: RTL and testbench
=================================

# wb_mult8_slave

Wishbone classic slave that fronts an 8x8 unsigned shift-add sequential multiplier and answers the management SoC's Wishbone initiator on the user project wrapper's `wbs_*` port. Firmware writes two operands, writes a start bit, then polls status or takes an interrupt and reads a 16-bit product. It instantiates beside the IO-pin multiplier in `user_project_wrapper` and drives `wbs_ack_o`, `wbs_dat_o` and `user_irq[0]`.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: block base address; decode compares `wbs_adr_i[31:4]` with `BASE_ADDR[31:4]`.
- `wb_clk_i` input 1: the only clock.
- `wb_rst_i` input 1: reset, asynchronous, active-high.
- `wbs_stb_i` input 1: strobe.
- `wbs_cyc_i` input 1: bus cycle valid.
- `wbs_we_i` input 1: 1 = write.
- `wbs_sel_i` input 4: byte-lane enables.
- `wbs_adr_i` input 32: byte address.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: one-cycle acknowledge.
- `wbs_dat_o` output 32: read data; valid only while ack is high, 0 otherwise.
- `irq` output 1: done interrupt, level-sensitive.

## Operation
- Hit condition: `wbs_cyc_i & wbs_stb_i` high and address matches `BASE_ADDR`. On a miss the block gives no ack and no side effects.
- Register map:
  - 0x00 OPERANDS (RW): [7:0] A, [15:8] B, other bits read 0. Writes honour `wbs_sel_i[0]` and `wbs_sel_i[1]`.
  - 0x04 CTRL/STATUS:
    - bit0 START (write 1 to start; reads back BUSY)
    - bit1 DONE (RO, sticky)
    - bit2 OVERRUN (W1C, sticky)
    - bit3 IE (RW, present only with the macro, else reads 0)
  - 0x08 RESULT (RO): [15:0] product. A read clears DONE. Writes are ignored but still acked.
  - 0x0C: reads 0, writes are ignored, and the access is acked.
- FSM states:
  - IDLE: START write with BUSY=0 → RUN. Operand registers are copied into working regs, acc=0, cnt=0, and DONE is cleared.
  - RUN: each cycle, if mcand bit cnt is set, acc += B<<cnt, then cnt++. After the 8th iteration: RESULT<=acc, DONE<=1, go to IDLE.
- Start while BUSY: the write is ignored, OVERRUN is set, and the in-flight operation and RESULT are unaffected.
- A write to OPERANDS while BUSY updates the register only. The running product uses the working copies.
- Arithmetic is unsigned with 16-bit acc and no overflow possible: 0xFF×0xFF=0xFE01.
- Simultaneous events:
  - DONE set and a RESULT read on the same edge: set wins.
  - An OVERRUN W1C and a new overrun on the same edge: set wins.

## Timing
- ack is registered: `ack <= hit & ~ack`. It rises one edge after stb and cyc are seen, stays high for exactly 1 cycle, and has no back-to-back acks. The master must hold stb until it sees ack.
- Write side effects and read data capture occur on the same edge that raises ack.
- Start accepted at edge E0 → BUSY=1 from E0. Iterations run at E1..E8. At E8: RESULT valid, DONE=1, BUSY=0.
- Latency from start acceptance to DONE is 8 cycles. The earliest next accepted start is an access whose ack edge is E9 or later; a start whose ack edge is E8 samples BUSY=1 and flags OVERRUN.
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0, operands=0, RESULT=0, BUSY/DONE/OVERRUN/IE=0, FSM=IDLE.
- Reset asserted mid-RUN aborts immediately to those values. No partial result is retained.

## Configuration
- `WB_MULT8_IRQ_EN` defined: CTRL bit3 IE is implemented, and `irq` = DONE & IE (level; it drops when a RESULT read clears DONE).
- `WB_MULT8_IRQ_EN` undefined: IE reads 0 and writes to it are ignored, `irq` is tied to 0, and firmware must poll DONE.

## Test plan
- Reset: hold `wb_rst_i`, release → all outputs 0, and reads of 0x00/0x04/0x08 return 0.
- Write 0x00=0x0000_FFFF, write 0x04=1, poll 0x04 → BUSY for 8 cycles after the start ack, then 0x2. Read 0x08 → 0x0000_FE01, and a re-read of 0x04 gives 0.
- Write 0x00 with sel=4'b0010 and data 0x0B00 after A=0x0D, then start → RESULT 0x008F. A start with A=0 or B=0 → RESULT 0.
- Start, issue a second start 2 cycles later → 0x04 reads 0x5 (BUSY|OVERRUN), and the first product completes correctly. Write 0x04=0x4 → OVERRUN cleared.
- Read 0x3000_0010 → no ack within 16 cycles. Read 0x0C → ack, data 0.
- With `WB_MULT8_IRQ_EN`:
  - Set IE, start → `irq` rises at E8 and falls after the RESULT read.
  - Assert reset at E3 → BUSY=0, RESULT=0, `irq`=0.

Source files
------------

// File: rtl/wb_mult8_slave.sv
// wb_mult8_slave
// Wishbone classic slave wrapped around an 8x8 unsigned shift-add multiplier.
// Firmware loads operands, writes START, then polls DONE (or takes the done
// interrupt) and reads the 16-bit product.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 OPERANDS    [7:0] A, [15:8] B (byte lanes 0/1 honoured)
//   0x04 CTRL/STATUS bit0 START/BUSY, bit1 DONE, bit2 OVERRUN (W1C), bit3 IE
//   0x08 RESULT      [15:0] product, read clears DONE
//   0x0C reserved    reads 0, writes ignored
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_stb_i, wbs_cyc_i        Wishbone strobe / cycle
//   wbs_we_i, wbs_sel_i         write enable, byte-lane enables
//   wbs_adr_i, wbs_dat_i        byte address, write data
//   wbs_ack_o, wbs_dat_o        one-cycle acknowledge, read data (0 unless acking)
//   irq                         level-sensitive done interrupt
//
// Configuration macro: WB_MULT8_IRQ_EN enables the IE bit and drives
// irq = DONE & IE. Without it IE reads 0 and irq is tied low.
module wb_mult8_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  work_a;
    logic [7:0]  work_b;
    logic [15:0] acc;
    logic [15:0] acc_sum;
    logic [15:0] result;
    logic [2:0]  cnt;
    logic        done;
    logic        overrun;
    logic        ie;
    logic        busy;
    logic        hit;
    logic        access;
    logic        wr;
    logic        rd;
    logic [1:0]  reg_sel;
    logic        start_req;
    logic        start_ok;
    logic        finish;
    logic [31:0] rd_mux;
    logic        unused;

    // Side effects happen only on the edge that raises ack, so a held strobe
    // is acted on exactly once.
    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign access    = hit & ~wbs_ack_o;
    assign wr        = access & wbs_we_i;
    assign rd        = access & ~wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];
    assign busy      = (state == RUN);
    assign start_req = wr & (reg_sel == 2'd1) & wbs_dat_i[0];

    // One shift-add step: add B shifted by the iteration index when the
    // corresponding multiplicand bit is set.
    assign acc_sum = acc + (work_a[cnt] ? ({8'h00, work_b} << cnt) : 16'h0000);

`ifdef WB_MULT8_IRQ_EN
    assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};
`else
    assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_dat_i[3], wbs_adr_i[1:0]};
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    start_ok   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == 3'd7) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand registers stay writable while busy; the multiplier only ever
    // sees the working copies latched at start.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_a   <= 8'h00;
            op_b   <= 8'h00;
            work_a <= 8'h00;
            work_b <= 8'h00;
            acc    <= 16'h0000;
            cnt    <= 3'd0;
            result <= 16'h0000;
        end else begin
            if (wr && reg_sel == 2'd0) begin
                if (wbs_sel_i[0]) op_a <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) op_b <= wbs_dat_i[15:8];
            end
            if (start_ok) begin
                work_a <= op_a;
                work_b <= op_b;
                acc    <= 16'h0000;
                cnt    <= 3'd0;
            end else if (busy) begin
                acc <= acc_sum;
                cnt <= cnt + 3'd1;
                if (finish) result <= acc_sum;
            end
        end
    end

    // Sticky status flags; in both cases a set on the same edge beats a clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (finish) begin
                done <= 1'b1;
            end else if (start_ok || (rd && reg_sel == 2'd2)) begin
                done <= 1'b0;
            end
            if (start_req && busy) begin
                overrun <= 1'b1;
            end else if (wr && reg_sel == 2'd1 && wbs_dat_i[2]) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef WB_MULT8_IRQ_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ie <= 1'b0;
        end else if (wr && reg_sel == 2'd1) begin
            ie <= wbs_dat_i[3];
        end
    end
    assign irq = done & ie;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            2'd0:    rd_mux = {16'h0000, op_b, op_a};
            2'd1:    rd_mux = {28'h0, ie, overrun, done, busy};
            2'd2:    rd_mux = {16'h0000, result};
            default: rd_mux = 32'h0;
        endcase
    end

    // Ack never fires on consecutive cycles; read data is zero whenever ack is low.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= hit & ~wbs_ack_o;
            wbs_dat_o <= rd ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_mult8_slave.sv
// tb_wb_mult8_slave
// Self-checking bench for wb_mult8_slave. A timing-aware behavioural model
// (product = A*B, completion at start edge + 8) predicts every read value,
// ack and irq level. Honours WB_MULT8_IRQ_EN when the same macro is set.
module tb_wb_mult8_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_MULT8_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    // Behavioural model state
    logic [7:0]  m_a, m_b;
    logic [15:0] m_result, m_pend;
    bit          m_done, m_over, m_ie, m_busy;
    int          m_end;

    wb_mult8_slave #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_result = 0; m_pend = 0;
        m_done = 0; m_over = 0; m_ie = 0; m_busy = 0; m_end = 0;
    endtask

    // Retire the running product once its completion edge has been reached.
    task automatic model_complete(input int e, input bit inclusive);
        if (m_busy && (e > m_end || (inclusive && e == m_end))) begin
            m_result = m_pend;
            m_done   = 1;
            m_busy   = 0;
        end
    endtask

    task automatic check_irq(input string tag);
        bit d;
        d = m_done || (m_busy && edge_cnt >= m_end);
        check_output(tag, {31'h0, irq}, {31'h0, d & m_ie});
    endtask

    task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string tag, output logic [31:0] rdata);
        bit acked;
        bit hit;
        int e;
        logic [31:0] exp_rd;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
        acked = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1;
                break;
            end
        end
        rdata = dat_o;
        e = edge_cnt;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        hit = (a[31:4] == BASE[31:4]);
        check_output({tag, "_ack"}, {31'h0, acked}, {31'h0, hit});
        if (hit && acked) begin
            model_complete(e, 0);
            exp_rd = 32'h0;
            case (a[3:2])
                2'd0: exp_rd = {16'h0, m_b, m_a};
                2'd1: exp_rd = {28'h0, m_ie, m_over, m_done, m_busy};
                2'd2: exp_rd = {16'h0, m_result};
                default: exp_rd = 32'h0;
            endcase
            if (!w) check_output({tag, "_rd"}, rdata, exp_rd);
            if (!w && a[3:2] == 2'd2) m_done = 0;
            if (w && a[3:2] == 2'd0) begin
                if (s[0]) m_a = d[7:0];
                if (s[1]) m_b = d[15:8];
            end
            if (w && a[3:2] == 2'd1) begin
                if (d[2]) m_over = 0;
                if (IRQ_EN) m_ie = d[3];
                if (d[0]) begin
                    if (m_busy) begin
                        m_over = 1;
                    end else begin
                        m_busy = 1;
                        m_end  = e + 8;
                        m_pend = m_a * m_b;
                        m_done = 0;
                    end
                end
            end
            model_complete(e, 1);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        logic [31:0] junk;
        wb_access(1'b1, a, d, s, tag, junk);
    endtask

    task automatic wb_read(input logic [31:0] a, input string tag, output logic [31:0] r);
        wb_access(1'b0, a, 32'h0, 4'hF, tag, r);
    endtask

    task automatic poll_done(input string tag);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 24; i++) begin
            wb_read(BASE + 32'h4, tag, r);
            if (r[1]) break;
        end
        check_output({tag, "_done"}, {31'h0, r[1]}, 32'h1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        check_output("rst_ack", {31'h0, ack}, 32'h0);
        check_output("rst_dat", dat_o, 32'h0);
        check_output("rst_irq", {31'h0, irq}, 32'h0);
        rst = 0;
        model_reset();
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  a, b;
        model_reset();

        // Reset values
        apply_stimulus_reset();
        wb_read(BASE + 32'h0, "rst_op", r);
        wb_read(BASE + 32'h4, "rst_ctrl", r);
        wb_read(BASE + 32'h8, "rst_res", r);

        // Largest operands
        wb_write(BASE + 32'h0, 32'h0000_FFFF, 4'hF, "ff_op");
        wb_write(BASE + 32'h4, 32'h1, 4'hF, "ff_start");
        poll_done("ff_poll");
        wb_read(BASE + 32'h8, "ff_res", r);
        wb_read(BASE + 32'h4, "ff_ctrl", r);

        // Byte-lane writes
        wb_write(BASE + 32'h0, 32'h0000_000D, 4'b0001, "lane_a");
        wb_write(BASE + 32'h0, 32'hFFFF_0B77, 4'b0010, "lane_b");
        wb_read(BASE + 32'h0, "lane_op", r);
        wb_write(BASE + 32'h4, 32'h1, 4'hF, "lane_start");
        poll_done("lane_poll");
        wb_read(BASE + 32'h8, "lane_res", r);

        // Zero operands
        wb_write(BASE + 32'h0, {16'h0, 8'($urandom), 8'h00}, 4'hF, "a0_op");
        wb_write(BASE + 32'h4, 32'h1, 4'hF, "a0_start");
        poll_done("a0_poll");
        wb_read(BASE + 32'h8, "a0_res", r);
        wb_write(BASE + 32'h0, {16'h0, 8'h00, 8'($urandom)}, 4'hF, "b0_op");
        wb_write(BASE + 32'h4, 32'h1, 4'hF, "b0_start");
        poll_done("b0_poll");
        wb_read(BASE + 32'h8, "b0_res", r);

        // Start while busy, operand write while busy, overrun clear
        wb_write(BASE + 32'h0, 32'h0000_C3A5, 4'hF, "ov_op");
        wb_write(BASE + 32'h4, 32'h1, 4'hF, "ov_start");
        wb_write(BASE + 32'h4, 32'h1, 4'hF, "ov_start2");
        wb_write(BASE + 32'h0, 32'h0000_1111, 4'hF, "ov_opbusy");
        wb_read(BASE + 32'h4, "ov_ctrl", r);
        poll_done("ov_poll");
        wb_read(BASE + 32'h8, "ov_res", r);
        wb_write(BASE + 32'h4, 32'h4, 4'hF, "ov_clr");
        wb_read(BASE + 32'h4, "ov_ctrl2", r);

        // Second start landing on the completion edge (E8) and one after (E9)
        for (int n = 6; n <= 7; n++) begin
            wb_write(BASE + 32'h4, 32'h1, 4'hF, "edge_start");
            wait_cycles(n);
            wb_write(BASE + 32'h4, 32'h1, 4'hF, "edge_start2");
            wb_read(BASE + 32'h4, "edge_ctrl", r);
            poll_done("edge_poll");
            wb_read(BASE + 32'h8, "edge_res", r);
            wb_write(BASE + 32'h4, 32'h4, 4'hF, "edge_clr");
        end

        // Address decode: miss, reserved slot, read-only RESULT
        wb_read(BASE + 32'h10, "miss", r);
        check_output("miss_dat", dat_o, 32'h0);
        wb_read(BASE + 32'hC, "rsvd_rd", r);
        wb_write(BASE + 32'hC, $urandom, 4'hF, "rsvd_wr");
        wb_write(BASE + 32'h8, $urandom, 4'hF, "res_wr");
        wb_read(BASE + 32'h8, "res_rd", r);

        // Randomized operations with a randomly timed second start
        for (int k = 0; k < 10; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            wb_write(BASE + 32'h0, {16'h0, b, a}, 4'hF, "rnd_op");
            wb_write(BASE + 32'h0, $urandom, 4'($urandom), "rnd_lane");
            wb_write(BASE + 32'h4, 32'h1, 4'hF, "rnd_start");
            wait_cycles($urandom_range(0, 10));
            wb_write(BASE + 32'h4, {28'h0, 4'($urandom) & 4'b0101}, 4'hF, "rnd_ctrl");
            poll_done("rnd_poll");
            wb_read(BASE + 32'h8, "rnd_res", r);
            wb_read(BASE + 32'h4, "rnd_stat", r);
            wb_write(BASE + 32'h4, 32'h4, 4'hF, "rnd_clr");
        end

        // Interrupt enable: irq follows DONE & IE cycle by cycle
        wb_write(BASE + 32'h0, 32'h0000_0F0E, 4'hF, "ie_op");
        wb_write(BASE + 32'h4, 32'h9, 4'hF, "ie_start");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_irq("ie_irq");
        end
        wb_read(BASE + 32'h4, "ie_ctrl", r);
        wb_read(BASE + 32'h8, "ie_res", r);
        check_irq("ie_irq_clr");

        // Reset mid-run at E3
        wb_write(BASE + 32'h0, 32'h0000_7733, 4'hF, "mr_op");
        wb_write(BASE + 32'h4, 32'h9, 4'hF, "mr_start");
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check_output("mr_irq", {31'h0, irq}, 32'h0);
        check_output("mr_ack", {31'h0, ack}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        wb_read(BASE + 32'h4, "mr_ctrl", r);
        wb_read(BASE + 32'h8, "mr_res", r);
        wb_read(BASE + 32'h0, "mr_op_rd", r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
